// File: rtl/subbytes_seq.sv
// subbytes_seq: iterative AES SubBytes engine.
//   One 128-bit state is accepted on the input valid/ready handshake. Its 16
//   bytes are substituted by LANES shared byte S-boxes over BEATS = 16/LANES
//   cycles. The finished state is then held on the output handshake until the
//   consumer takes it.
//
// Parameters:
//   LANES  S-box instances used per cycle (1, 2, 4, 8 or 16)
//   PIPE   0 = S-box results written on the same edge, 1 = one register stage
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input state valid
//   in_ready   engine can accept a state (high only in IDLE)
//   in_data    input state, byte i = in_data[8i+7:8i]
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   out_data   substituted state, same byte mapping as in_data
//   busy       high in any state other than IDLE
//   inv_mode   (SUBBYTES_SEQ_INV_EN builds only) 1 = InvSubBytes, sampled
//              on the input handshake
//
// Optional feature macro: SUBBYTES_SEQ_INV_EN adds inv_mode and the inverse
// S-box path. Timing is identical in both builds.
module subbytes_seq #(
   parameter int LANES = 4,
   parameter int PIPE  = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
`ifdef SUBBYTES_SEQ_INV_EN
   ,
   input  logic         inv_mode
`endif
);

   localparam int BEATS = 16 / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = LANES * 8;

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
      end
      if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
         $error("subbytes_seq: PIPE must be 0 or 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Byte S-box arithmetic in GF(2^8), polynomial x^8+x^4+x^3+x+1.
   // ------------------------------------------------------------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_sq(input logic [7:0] a);
      return gf_mul(a, a);
   endfunction

   // Inversion inside the GF(2^4) subfield: n^15 = 1, so n^-1 = n^14.
   function automatic logic [7:0] gf16_inv(input logic [7:0] n);
      logic [7:0] n2, n4, n8;
      n2 = gf_sq(n);
      n4 = gf_sq(n2);
      n8 = gf_sq(n4);
      return gf_mul(gf_mul(n8, n4), n2);
   endfunction

   // Composite-field inverse: the norm x^17 lies in the GF(2^4) subfield,
   // so x^-1 = x^16 * (x^17)^-1 needs only a subfield inversion.
   // x = 0 maps to 0 because x^16 = 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x16, nrm;
      x16 = gf_sq(gf_sq(gf_sq(gf_sq(x))));
      nrm = gf_mul(x16, x);
      return gf_mul(x16, gf16_inv(nrm));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

`ifdef SUBBYTES_SEQ_INV_EN
   function automatic logic [7:0] sbox_inv(input logic [7:0] a);
      logic [7:0] v;
      v = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(v);
   endfunction
`endif

   // ------------------------------------------------------------------
   // Control and datapath
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [127:0]  src_q;
   logic [127:0]  res_q;
   logic [LW-1:0] lane_in;
   logic [LW-1:0] lane_out;
   logic          wr_en;
   logic [CW-1:0] wr_idx;
   logic [LW-1:0] wr_data;
`ifdef SUBBYTES_SEQ_INV_EN
   logic          mode_q;
`endif

   always_comb begin
      lane_in = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         lane_in[k*8 +: 8] = src_q[(int'(cnt_q) * LANES + k) * 8 +: 8];
      end
   end

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef SUBBYTES_SEQ_INV_EN
         assign lane_out[k*8 +: 8] = mode_q ? sbox_inv(lane_in[k*8 +: 8])
                                            : sbox_fwd(lane_in[k*8 +: 8]);
`else
         assign lane_out[k*8 +: 8] = sbox_fwd(lane_in[k*8 +: 8]);
`endif
      end

      if (PIPE != 0) begin : g_pipe
         // Each RUN beat is held one cycle and written on the following edge;
         // the last beat lands during DRAIN.
         logic [LW-1:0] pipe_q;
         logic [CW-1:0] pidx_q;
         logic          pval_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_q <= '0;
               pidx_q <= '0;
               pval_q <= 1'b0;
            end else begin
               pipe_q <= lane_out;
               pidx_q <= cnt_q;
               pval_q <= (state_q == RUN);
            end
         end
         assign wr_en   = pval_q;
         assign wr_idx  = pidx_q;
         assign wr_data = pipe_q;
      end else begin : g_nopipe
         assign wr_en   = (state_q == RUN);
         assign wr_idx  = cnt_q;
         assign wr_data = lane_out;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         res_q   <= '0;
`ifdef SUBBYTES_SEQ_INV_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         if (wr_en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
               res_q[(int'(wr_idx) * LANES + k) * 8 +: 8] <= wr_data[k*8 +: 8];
            end
         end
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  src_q   <= in_data;
                  cnt_q   <= '0;
`ifdef SUBBYTES_SEQ_INV_EN
                  mode_q  <= inv_mode;
`endif
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (cnt_q == CW'(BEATS - 1)) begin
                  cnt_q   <= '0;
                  state_q <= (PIPE != 0) ? DRAIN : DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DRAIN: state_q <= DONE;
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = res_q;

endmodule

// File: tb/tb_subbytes_seq.sv
// tb_subbytes_seq: self-checking bench for subbytes_seq.
//   Three instances (LANES/PIPE = 4/0, 1/1, 16/0) share clock and reset.
//   Expected states come from S-box tables built from the field definition
//   (brute-force inverse search plus the bitwise affine rule) and from
//   known-answer constants.
module tb_subbytes_seq;

   localparam int NCFG = 3;

   function automatic int cfg_lanes(input int c);
      case (c)
         0: return 4;
         1: return 1;
         default: return 16;
      endcase
   endfunction

   function automatic int cfg_pipe(input int c);
      return (c == 1) ? 1 : 0;
   endfunction

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [NCFG];
   logic         in_ready  [NCFG];
   logic [127:0] in_data   [NCFG];
   logic         out_valid [NCFG];
   logic         out_ready [NCFG];
   logic [127:0] out_data  [NCFG];
   logic         busy      [NCFG];
`ifdef SUBBYTES_SEQ_INV_EN
   logic         inv_mode  [NCFG];
`endif

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NCFG; g++) begin : g_dut
         subbytes_seq #(.LANES(cfg_lanes(g)), .PIPE(cfg_pipe(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
`ifdef SUBBYTES_SEQ_INV_EN
            .inv_mode  (inv_mode[g]),
`endif
            .busy      (busy[g])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];
   logic       cur_mode;
   int         checks = 0;
   int         errors = 0;

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int unsigned x, y, p;
      x = a; y = b; p = 0;
      while (y != 0) begin
         if (y % 2 == 1) p = p ^ x;
         x = x * 2;
         if (x >= 256) x = x ^ 32'h11b;
         y = y / 2;
      end
      return 8'(p);
   endfunction

   task automatic build_tables;
      logic [7:0] c;
      logic [7:0] iv;
      logic [7:0] s;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         iv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (ref_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = iv[i] ^ iv[(i + 4) % 8] ^ iv[(i + 5) % 8] ^ iv[(i + 6) % 8] ^ iv[(i + 7) % 8] ^ c[i];
         end
         fwd_t[x] = s;
      end
      for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic m);
      logic [127:0] r;
      logic [7:0]   b;
      for (int i = 0; i < 16; i++) begin
         b = d[i*8 +: 8];
         r[i*8 +: 8] = m ? inv_t[b] : fwd_t[b];
      end
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Offer one state to instance c from IDLE, wait for out_valid (bounded),
   // check latency, busy and result. Leaves the instance in DONE.
   task automatic run_state(input int c, input logic [127:0] d, input logic [127:0] exp,
                            input string tag, output logic [127:0] got);
      int edges;
      bit busy_ok;
      chk({tag, "_in_ready"}, 128'(in_ready[c]), 128'd1);
      in_valid[c] = 1'b1;
      in_data[c]  = d;
`ifdef SUBBYTES_SEQ_INV_EN
      inv_mode[c] = cur_mode;
`endif
      tick;
      in_valid[c] = 1'b0;
      in_data[c]  = rnd128();
`ifdef SUBBYTES_SEQ_INV_EN
      inv_mode[c] = ~cur_mode;
`endif
      edges   = 0;
      busy_ok = 1'b1;
      while (out_valid[c] !== 1'b1 && edges < 200) begin
         if (busy[c] !== 1'b1) busy_ok = 1'b0;
         tick;
         edges++;
      end
      chk({tag, "_latency"}, 128'(edges), 128'(16 / cfg_lanes(c) + cfg_pipe(c)));
      chk({tag, "_busy_run"}, 128'(busy_ok), 128'd1);
      chk({tag, "_data"}, out_data[c], exp);
      got = out_data[c];
   endtask

   task automatic finish_state(input int c, input string tag);
      out_ready[c] = 1'b1;
      chk({tag, "_in_ready_done"}, 128'(in_ready[c]), 128'd0);
      tick;
      out_ready[c] = 1'b0;
      chk({tag, "_out_valid_idle"}, 128'(out_valid[c]), 128'd0);
      chk({tag, "_in_ready_idle"}, 128'(in_ready[c]), 128'd1);
      chk({tag, "_busy_idle"}, 128'(busy[c]), 128'd0);
   endtask

   // ------------------------------------------------------------------
   // Directed and random sequence
   // ------------------------------------------------------------------
   initial begin
      logic [127:0] got;
      logic [127:0] d;
      build_tables();
      cur_mode = 1'b0;
      rst_n = 1'b0;
      for (int c = 0; c < NCFG; c++) begin
         in_valid[c]  = 1'b0;
         in_data[c]   = '0;
         out_ready[c] = 1'b0;
`ifdef SUBBYTES_SEQ_INV_EN
         inv_mode[c]  = 1'b0;
`endif
      end
      #22;
      chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
      chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("rst_busy", 128'(busy[0]), 128'd0);
      chk("rst_out_data", out_data[0], '0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      // All-zero state, LANES=4 PIPE=0
      run_state(0, '0, {16{8'h63}}, "zero_l4", got);
      finish_state(0, "zero_l4");

      // Bytes 00..0f, LANES=1 PIPE=1
      run_state(1, 128'h0f0e0d0c0b0a09080706050403020100,
                128'h76abd7fe2b670130c56f6bf27b777c63, "seq_l1p1", got);
      finish_state(1, "seq_l1p1");

      // Edge bytes, LANES=16
      run_state(2, 128'hff010101010101010101010101010153,
                128'h167c7c7c7c7c7c7c7c7c7c7c7c7c7ced, "edge_l16", got);
      finish_state(2, "edge_l16");

      // Backpressure in DONE with a competing in_valid
      d = rnd128();
      run_state(0, d, model(d, 1'b0), "bp", got);
      for (int i = 0; i < 10; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = rnd128();
         tick;
         chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
         chk("bp_out_data", out_data[0], got);
         chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
      end
      in_valid[0] = 1'b0;
      finish_state(0, "bp");
      chk("bp_data_kept", out_data[0], model(d, 1'b0));

      // Random states on every configuration
      for (int c = 0; c < NCFG; c++) begin
         for (int n = 0; n < 4; n++) begin
            d = rnd128();
`ifdef SUBBYTES_SEQ_INV_EN
            cur_mode = 1'($urandom_range(0, 1));
`endif
            run_state(c, d, model(d, cur_mode), "rand", got);
            finish_state(c, "rand");
         end
      end
      cur_mode = 1'b0;

      // Asynchronous reset mid-RUN (cnt = 2) on LANES=4
      in_valid[0] = 1'b1;
      in_data[0]  = rnd128();
      tick;
      in_valid[0] = 1'b0;
      tick;
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 128'(in_ready[0]), 128'd1);
      chk("arst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("arst_busy", 128'(busy[0]), 128'd0);
      chk("arst_out_data", out_data[0], '0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      run_state(0, {16{8'h01}}, {16{8'h7c}}, "post_rst", got);
      finish_state(0, "post_rst");

`ifdef SUBBYTES_SEQ_INV_EN
      cur_mode = 1'b1;
      run_state(0, {16{8'h63}}, '0, "inv_63", got);
      finish_state(0, "inv_63");
      cur_mode = 1'b0;
      run_state(0, '0, {16{8'h63}}, "fwd_00", got);
      finish_state(0, "fwd_00");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/subbytes_seq.md
Name: subbytes_seq

Overview:
- Iterative AES SubBytes engine: accepts one 128-bit state and substitutes all 16 bytes through LANES shared byte S-box instances over 16/LANES cycles.
- Each S-box instance is the team's composite-field byte S-box, built around the GF(2^4) inversion core.
- Sits between the round-key/ShiftRows datapath and round control in the area-optimised AES core.
- valid/ready handshake on both sides.

Parameters:
- LANES, 4, number of S-box instances used per cycle. Legal values are 1, 2, 4, 8, 16. Any other value is an elaboration error.
- PIPE, 0, register stage after the S-box outputs. 0 = none, 1 = one stage.
- Derived: BEATS = 16/LANES. The beat counter width is clog2(BEATS), minimum 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  engine can accept a state
- in_data  in  128  input state; byte i = in_data[8i+7:8i]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  128  substituted state, same byte mapping as in_data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- States: IDLE, RUN, DRAIN, DONE.
- Reset (rst_n=0, any time, including mid-RUN): state forced to IDLE immediately. beat counter=0, source and result registers=0. Resulting outputs: in_ready=1, out_valid=0, busy=0, out_data=0. Any in-flight state is discarded without a partial output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the source register, set cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, lane k substitutes source byte cnt*LANES+k, for k=0..LANES-1. Bytes are processed in ascending index order.
  - PIPE=0: results are written to result bytes cnt*LANES+k on the same edge.
  - PIPE=1: results are registered and written one edge later.
  - cnt increments by 1 each cycle. When cnt==BEATS-1, go to DRAIN if PIPE=1, else DONE. cnt wraps to 0.
- DRAIN (PIPE=1 only): one cycle; writes the final beat's results; go to DONE.
- DONE:
  - out_valid=1 and out_data=result register; both held stable while out_ready=0.
  - On out_ready=1: go to IDLE; out_valid deasserts on the next edge.
  - A new input is not accepted in the handshake cycle, since in_ready=0 in DONE.
- Latency: the accept edge is edge 0; out_valid rises after edge BEATS+PIPE.
  - LANES=4, PIPE=0: out_valid high after 4 edges.
  - LANES=1, PIPE=1: out_valid high after 17 edges.
  - Minimum throughput interval: BEATS+PIPE+2 cycles per state (IDLE and DONE cycles included).
- in_data changes after acceptance have no effect (source register). in_valid asserted outside IDLE is ignored and not acknowledged.
- S-box function: AES forward S-box per FIPS-197, i.e. GF(2^8) inverse followed by the affine transform (constant 0x63).
- No X on any output after reset.

Optional Feature:
- Macro: SUBBYTES_SEQ_INV_EN.
- Defined:
  - Adds input port inv_mode (1 bit).
  - inv_mode is sampled into a mode register on the input handshake and ignored at other times.
  - mode=1: every lane computes the inverse S-box (inverse affine, then GF(2^8) inverse), i.e. InvSubBytes. mode=0: forward S-box.
  - The mode register resets to 0.
- Undefined: inv_mode port absent; forward S-box only. Timing is identical in both builds.

Test Plan:
- Reset then all-zero input, LANES=4, PIPE=0 -> out_valid after exactly 4 edges; out_data=0x6363...63 (16 bytes); busy high for cycles 1..5.
- in_data bytes 0..15 = 0x00..0x0F (byte0=0x00), LANES=1, PIPE=1 -> after 17 edges, out bytes 0..15 = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0, a new in_valid is not accepted; out_ready=1 -> IDLE next edge, then in_ready=1.
- Byte checks with LANES=16: byte0=0x53, byte15=0xFF, others 0x01 -> out byte0=0xED, byte15=0x16, others 0x7C; out_valid after 1 edge (PIPE=0).
- Assert rst_n=0 asynchronously mid-RUN (cnt=2, LANES=4) -> outputs return to reset values without waiting for a clock edge; the next accepted state (all 0x01) yields all 0x7C with normal latency.
- SUBBYTES_SEQ_INV_EN defined: inv_mode=1, in all 0x63 -> out all 0x00; back-to-back with inv_mode=0, in all 0x00 -> out all 0x63.
